// File: rtl/uram_event_readout_sm_v2.sv
// Event readout sequencer for a cascaded URAM/BRAM event buffer.
// Walks header words, then each enabled channel's memories group by group.
module uram_event_readout_sm_v2 #(
  parameter int NCHAN      = 8,
  parameter int NBRAM      = 3,
  parameter int NHDR       = 4,
  parameter int UADDR_BITS = 7,
  parameter int LADDR_BITS = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clk_ce_i,
  input  logic                             data_available_i,
  input  logic [NCHAN-1:0]                 chan_mask_i,
  input  logic                             ready_i,
  output logic                             complete_o,
  output logic [UADDR_BITS+LADDR_BITS-1:0] bram_addr_o,
  output logic [NBRAM-1:0]                 bram_en_o,
  output logic [NBRAM-1:0]                 casdomux_o,
  output logic                             casdomuxen_o,
  output logic [NCHAN-1:0]                 channel_en_o,
  output logic                             sel_header_o,
  output logic                             header_rd_o,
  output logic                             valid_o
);

  localparam int HW = $clog2(NHDR);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    STALL
  } state_t;

  state_t                  state_q, state_d;
  logic [HW-1:0]           hdr_q, hdr_d;
  logic [LADDR_BITS-1:0]   laddr_q, laddr_d;
  logic [UADDR_BITS-1:0]   uaddr_q, uaddr_d;
  logic [NCHAN-1:0]        mask_q, mask_d;
  logic [NCHAN-1:0]        chan_q, chan_d;
  logic [NBRAM-1:0]        ben_q, ben_d;
  logic                    valid_q, valid_d;
  logic                    moved_q, moved_d;

  logic                    laddr_max;
  logic                    last_mem;
  logic                    chan_end;
  logic                    ev_end;
  logic                    hdr_last;
  logic                    do_step;
  logic                    complete_c;
  logic                    hdr_rd_c;
  logic                    cmux_c;
  logic [NCHAN-1:0]        nxt_chan;

  // Lowest set mask bit strictly above cur; cur==0 yields the lowest set bit.
  function automatic logic [NCHAN-1:0] next_chan(
    input logic [NCHAN-1:0] m,
    input logic [NCHAN-1:0] cur
  );
    logic [NCHAN-1:0] res;
    logic             seen;
    logic             found;
    res   = '0;
    seen  = (cur == '0);
    found = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (seen && !found && m[i]) begin
        res[i] = 1'b1;
        found  = 1'b1;
      end
      if (cur[i]) seen = 1'b1;
    end
    return res;
  endfunction

  assign laddr_max = &laddr_q;
  assign last_mem  = ben_q[NBRAM-1];
  assign chan_end  = laddr_max && last_mem && (&uaddr_q);
  assign nxt_chan  = next_chan(mask_q, chan_q);
  // Once the channel select has moved early, this cannot be the event end.
  assign ev_end    = chan_end && !moved_q && (nxt_chan == '0);
  assign hdr_last  = (hdr_q == HW'(NHDR - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      laddr_q <= '0;
      uaddr_q <= '0;
      mask_q  <= '0;
      chan_q  <= '0;
      ben_q   <= '0;
      valid_q <= 1'b0;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      laddr_q <= laddr_d;
      uaddr_q <= uaddr_d;
      mask_q  <= mask_d;
      chan_q  <= chan_d;
      ben_q   <= ben_d;
      valid_q <= valid_d;
      moved_q <= moved_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    laddr_d    = laddr_q;
    uaddr_d    = uaddr_q;
    mask_d     = mask_q;
    chan_d     = chan_q;
    ben_d      = ben_q;
    valid_d    = valid_q;
    moved_d    = moved_q;
    do_step    = 1'b0;
    complete_c = 1'b0;
    hdr_rd_c   = 1'b0;
    cmux_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clk_ce_i) begin
          laddr_d = LADDR_BITS'(1);
          moved_d = 1'b0;
          if (data_available_i) begin
            mask_d  = chan_mask_i;
            hdr_d   = '0;
            uaddr_d = '0;
            valid_d = 1'b1;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (clk_ce_i) begin
          laddr_d = laddr_q + LADDR_BITS'(1);
          hdr_d   = hdr_q + HW'(1);
          if (hdr_last) begin
            hdr_rd_c = 1'b1;
            cmux_c   = 1'b1;
            hdr_d    = '0;
            if (mask_q == '0) begin
              complete_c = 1'b1;
              valid_d    = 1'b0;
              laddr_d    = LADDR_BITS'(1);
              state_d    = IDLE;
            end else begin
              // Data walk always starts from group address 0.
              laddr_d = '0;
              ben_d   = NBRAM'(1);
              chan_d  = nxt_chan;
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        // Move channel select on the idle clock so the output mux settles.
        if (!clk_ce_i && chan_end && !moved_q && (nxt_chan != '0)) begin
          chan_d  = nxt_chan;
          moved_d = 1'b1;
        end
        if (clk_ce_i) begin
          if (!laddr_max) begin
            laddr_d = laddr_q + LADDR_BITS'(1);
          end else if (ev_end) begin
            complete_c = 1'b1;
            valid_d    = 1'b0;
            ben_d      = '0;
            chan_d     = '0;
            laddr_d    = LADDR_BITS'(1);
            uaddr_d    = '0;
            state_d    = IDLE;
          end else if (!ready_i) begin
            valid_d = 1'b0;
            state_d = STALL;
          end else begin
            do_step = 1'b1;
          end
        end
      end
      STALL: begin
        if (clk_ce_i && ready_i) begin
          do_step = 1'b1;
          valid_d = 1'b1;
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase

    // Group-boundary step shared by DATA and the STALL release.
    if (do_step) begin
      cmux_c  = 1'b1;
      laddr_d = '0;
      ben_d   = {ben_q[NBRAM-2:0], ben_q[NBRAM-1]};
      moved_d = 1'b0;
      if (last_mem) uaddr_d = uaddr_q + UADDR_BITS'(1);
      if (chan_end && !moved_q) chan_d = nxt_chan;
    end
  end

  assign complete_o   = complete_c && !rst_i;
  assign header_rd_o  = hdr_rd_c && !rst_i;
  assign casdomuxen_o = cmux_c && !rst_i;
  assign sel_header_o = (state_q == HDR);
  assign valid_o      = valid_q;
  assign bram_addr_o  = {uaddr_q, laddr_q};
  assign bram_en_o    = ben_q;
  assign casdomux_o   = ~ben_q;
  assign channel_en_o = chan_q;

endmodule

// File: tb/tb_uram_event_readout_sm_v2.sv
// Bench for uram_event_readout_sm_v2: default instance plus a small
// NCHAN=4/NBRAM=2/UADDR_BITS=3/NHDR=6 instance.
module tb_uram_event_readout_sm_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       dav;
  logic       ready;
  logic [7:0] mask;

  logic       complete_o;
  logic [8:0] bram_addr_o;
  logic [2:0] bram_en_o;
  logic [2:0] casdomux_o;
  logic       casdomuxen_o;
  logic [7:0] channel_en_o;
  logic       sel_header_o;
  logic       header_rd_o;
  logic       valid_o;

  logic       dav2;
  logic [3:0] mask2;
  logic       complete2;
  logic [4:0] addr2;
  logic [1:0] ben2;
  logic [1:0] cmux2;
  logic       cmuxen2;
  logic [3:0] chan2;
  logic       sel2;
  logic       hrd2;
  logic       valid2;

  always #5 clk = ~clk;

  uram_event_readout_sm_v2 dut (
    .clk_i(clk), .rst_i(rst), .clk_ce_i(ce),
    .data_available_i(dav), .chan_mask_i(mask),
    .ready_i(ready), .complete_o(complete_o),
    .bram_addr_o(bram_addr_o), .bram_en_o(bram_en_o),
    .casdomux_o(casdomux_o), .casdomuxen_o(casdomuxen_o),
    .channel_en_o(channel_en_o), .sel_header_o(sel_header_o),
    .header_rd_o(header_rd_o), .valid_o(valid_o)
  );

  uram_event_readout_sm_v2 #(
    .NCHAN(4), .NBRAM(2), .NHDR(6),
    .UADDR_BITS(3), .LADDR_BITS(2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .clk_ce_i(ce),
    .data_available_i(dav2), .chan_mask_i(mask2),
    .ready_i(ready), .complete_o(complete2),
    .bram_addr_o(addr2), .bram_en_o(ben2),
    .casdomux_o(cmux2), .casdomuxen_o(cmuxen2),
    .channel_en_o(chan2), .sel_header_o(sel2),
    .header_rd_o(hrd2), .valid_o(valid2)
  );

  int checks = 0;
  int passed = 0;

  logic [19:0] q[$];
  logic [10:0] q2[$];

  int          n_hdr, n_data, n_cmp, n_hrd, n_vce, n_cmux;
  int          seq_err, cmp_hdr, nch;
  bit          ben_seen;
  logic [7:0]  chseq[8];
  logic [19:0] cmp_word, bad_got, bad_exp;

  task automatic clear_stats();
    n_hdr = 0; n_data = 0; n_cmp = 0; n_hrd = 0;
    n_vce = 0; n_cmux = 0; seq_err = 0; cmp_hdr = 0;
    nch = 0; ben_seen = 0;
    cmp_word = '0; bad_got = '0; bad_exp = '0;
    for (int i = 0; i < 8; i++) chseq[i] = '0;
  endtask

  // Expected {channel_en, bram_en, addr} for each data ce-cycle of an event.
  task automatic push_event(input logic [7:0] m, input bit alt);
    logic [7:0] ch, nx;
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        nx = '0;
        for (int k = 7; k > c; k--) if (m[k]) nx = 8'(1) << k;
        for (int u = 0; u < 128; u++)
          for (int b = 0; b < 3; b++)
            for (int l = 0; l < 4; l++) begin
              ch = 8'(1) << c;
              if (alt && nx != 0 && u == 127 && b == 2 && l == 3) ch = nx;
              q.push_back({ch, 3'(1 << b), 9'(u * 4 + l)});
            end
      end
    end
  endtask

  task automatic cyc(input bit c, input bit r, input bit d);
    logic [19:0] got, exp;
    ce = c; ready = r; dav = d;
    @(negedge clk);
    if (bram_en_o != 0) ben_seen = 1;
    if (c) begin
      if (sel_header_o) n_hdr++;
      if (valid_o) n_vce++;
      if (header_rd_o) n_hrd++;
      if (casdomuxen_o) n_cmux++;
      if (complete_o) begin
        n_cmp++;
        cmp_hdr  = n_hdr;
        cmp_word = {channel_en_o, bram_en_o, bram_addr_o};
      end
      if (valid_o && !sel_header_o && bram_en_o != 0) begin
        n_data++;
        got = {channel_en_o, bram_en_o, bram_addr_o};
        if (q.size() == 0) begin
          if (seq_err == 0) begin bad_got = got; bad_exp = '1; end
          seq_err++;
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin
            if (seq_err == 0) begin bad_got = got; bad_exp = exp; end
            seq_err++;
          end
        end
        if ((nch == 0 || chseq[nch-1] != channel_en_o) && nch < 8) begin
          chseq[nch] = channel_en_o;
          nch++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_event(input logic [7:0] m, input bit alt, input int limit);
    mask = m;
    q.delete();
    push_event(m, alt);
    clear_stats();
    cyc(1, 1, 1);
    for (int i = 0; i < limit && n_cmp == 0; i++)
      cyc(alt ? (i % 2 == 1) : 1'b1, 1, 0);
  endtask

  task automatic test_reset();
    rst = 1; ce = 1; dav = 0; ready = 1; mask = '0;
    dav2 = 0; mask2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bram_en_o !== 3'b000 || channel_en_o !== 8'h00)
      $display("FAIL reset_en got ben=%b ch=%h want 000/00", bram_en_o, channel_en_o);
    else passed++;
    checks++;
    if (bram_addr_o !== 9'h000)
      $display("FAIL reset_addr got %h want 000", bram_addr_o);
    else passed++;
    checks++;
    if (casdomux_o !== 3'b111)
      $display("FAIL reset_casdomux got %b want 111", casdomux_o);
    else passed++;
    checks++;
    if ({valid_o, complete_o, header_rd_o, casdomuxen_o, sel_header_o} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000",
               {valid_o, complete_o, header_rd_o, casdomuxen_o, sel_header_o});
    else passed++;
    @(posedge clk); #1;
    rst = 0;
    repeat (2) cyc(1, 1, 0);
  endtask

  task automatic test_full();
    run_event(8'hFF, 1, 24700);
    checks++;
    if (n_cmp !== 1) $display("FAIL full_complete got %0d want 1", n_cmp);
    else passed++;
    checks++;
    if (n_hdr !== 4) $display("FAIL full_hdr got %0d want 4", n_hdr);
    else passed++;
    checks++;
    if (n_data !== 12288) $display("FAIL full_data got %0d want 12288", n_data);
    else passed++;
    checks++;
    if (seq_err !== 0 || q.size() !== 0)
      $display("FAIL full_seq got %0d errs (%h vs %h) left %0d want 0",
               seq_err, bad_got, bad_exp, q.size());
    else passed++;
    checks++;
    if (n_hrd !== 1) $display("FAIL full_hdr_rd got %0d want 1", n_hrd);
    else passed++;
    repeat (8) cyc(1, 1, 0);
    checks++;
    if (n_cmp !== 1) $display("FAIL full_single_complete got %0d want 1", n_cmp);
    else passed++;
  endtask

  task automatic test_mask_skip();
    run_event(8'b1000_0101, 1, 9300);
    checks++;
    if (n_data !== 4608) $display("FAIL skip_data got %0d want 4608", n_data);
    else passed++;
    checks++;
    if (nch !== 3 || chseq[0] !== 8'h01 || chseq[1] !== 8'h04 || chseq[2] !== 8'h80)
      $display("FAIL skip_chseq got n=%0d %h %h %h want 3 01 04 80",
               nch, chseq[0], chseq[1], chseq[2]);
    else passed++;
    checks++;
    if (n_cmp !== 1 || cmp_word !== {8'h80, 3'b100, 9'h1FF})
      $display("FAIL skip_complete got n=%0d word=%h want 1 %h",
               n_cmp, cmp_word, {8'h80, 3'b100, 9'h1FF});
    else passed++;
    checks++;
    if (seq_err !== 0 || q.size() !== 0)
      $display("FAIL skip_seq got %0d errs (%h vs %h) want 0", seq_err, bad_got, bad_exp);
    else passed++;
  endtask

  task automatic test_mask_zero();
    run_event(8'h00, 1, 40);
    checks++;
    if (n_hdr !== 4 || n_cmp !== 1 || cmp_hdr !== 4)
      $display("FAIL zero_hdr got hdr=%0d cmp=%0d at=%0d want 4 1 4", n_hdr, n_cmp, cmp_hdr);
    else passed++;
    checks++;
    if (n_vce !== 4) $display("FAIL zero_valid got %0d want 4", n_vce);
    else passed++;
    checks++;
    if (ben_seen !== 0 || n_data !== 0)
      $display("FAIL zero_noben got seen=%0d data=%0d want 0 0", ben_seen, n_data);
    else passed++;
  endtask

  task automatic test_stall();
    int  frz_err, cm0, cm1;
    bit  stalled;
    logic [2:0] ben_rel;
    logic [8:0] addr_rel;
    logic       val_rel;
    frz_err = 0; stalled = 0; cm0 = 0; cm1 = 0;
    ben_rel = '0; addr_rel = '0; val_rel = 0;
    mask = 8'h01;
    q.delete();
    push_event(8'h01, 0);
    clear_stats();
    cyc(1, 1, 1);
    for (int i = 0; i < 1700 && n_cmp == 0; i++) begin
      if (!stalled && bram_addr_o == 9'h017 && bram_en_o == 3'b010) begin
        stalled = 1;
        cm0 = n_cmux;
        cyc(1, 0, 0);
        for (int k = 0; k < 9; k++) begin
          cyc(1, 0, 0);
          if (valid_o !== 0 || bram_addr_o !== 9'h017 ||
              bram_en_o !== 3'b010 || channel_en_o !== 8'h01) frz_err++;
        end
        cm1 = n_cmux;
        cyc(1, 1, 0);
        ben_rel = bram_en_o; addr_rel = bram_addr_o; val_rel = valid_o;
      end else begin
        cyc(1, 1, 0);
      end
    end
    checks++;
    if (stalled !== 1 || frz_err !== 0)
      $display("FAIL stall_frozen got stalled=%0d errs=%0d want 1 0", stalled, frz_err);
    else passed++;
    checks++;
    if (cm1 - cm0 !== 0) $display("FAIL stall_cmuxen got %0d want 0", cm1 - cm0);
    else passed++;
    checks++;
    if (ben_rel !== 3'b100 || addr_rel !== 9'h014 || val_rel !== 1)
      $display("FAIL stall_release got ben=%b addr=%h v=%0d want 100 014 1",
               ben_rel, addr_rel, val_rel);
    else passed++;
    checks++;
    if (seq_err !== 0 || n_data !== 1536 || n_cmp !== 1)
      $display("FAIL stall_seq got errs=%0d data=%0d cmp=%0d want 0 1536 1",
               seq_err, n_data, n_cmp);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit reached;
    reached = 0;
    mask = 8'h0C;
    q.delete();
    clear_stats();
    cyc(1, 1, 1);
    for (int i = 0; i < 5000 && !reached; i++) begin
      cyc(1, 1, 0);
      if (channel_en_o == 8'h08 && bram_addr_o == 9'h040) reached = 1;
    end
    rst = 1;
    cyc(1, 1, 0);
    checks++;
    if (reached !== 1) $display("FAIL rstmid_reach got %0d want 1", reached);
    else passed++;
    checks++;
    if ({bram_en_o, channel_en_o, bram_addr_o} !== 20'h0 || casdomux_o !== 3'b111 ||
        {valid_o, complete_o, header_rd_o, casdomuxen_o, sel_header_o} !== 5'b0)
      $display("FAIL rstmid_outputs got ben=%b ch=%h a=%h v=%0d sel=%0d want reset values",
               bram_en_o, channel_en_o, bram_addr_o, valid_o, sel_header_o);
    else passed++;
    checks++;
    if (n_cmp !== 0) $display("FAIL rstmid_nocomplete got %0d want 0", n_cmp);
    else passed++;
    rst = 0;
    cyc(1, 1, 0);
    run_event(8'h01, 0, 1700);
    checks++;
    if (n_hdr !== 4 || n_cmp !== 1 || n_data !== 1536 || seq_err !== 0)
      $display("FAIL rstmid_restart got hdr=%0d cmp=%0d data=%0d errs=%0d want 4 1 1536 0",
               n_hdr, n_cmp, n_data, seq_err);
    else passed++;
  endtask

  task automatic test_small();
    int h, dn, cm, er;
    logic [10:0] got, exp;
    h = 0; dn = 0; cm = 0; er = 0;
    q2.delete();
    for (int c = 0; c < 4; c++)
      for (int u = 0; u < 8; u++)
        for (int b = 0; b < 2; b++)
          for (int l = 0; l < 4; l++)
            q2.push_back({4'(1 << c), 2'(1 << b), 5'(u * 4 + l)});
    mask2 = 4'hF;
    ce = 1; ready = 1; dav2 = 1;
    @(posedge clk); #1;
    dav2 = 0;
    for (int i = 0; i < 400 && cm == 0; i++) begin
      @(negedge clk);
      if (sel2) h++;
      if (complete2) cm++;
      if (valid2 && !sel2 && ben2 != 0) begin
        dn++;
        got = {chan2, ben2, addr2};
        if (q2.size() == 0) er++;
        else begin
          exp = q2.pop_front();
          if (got !== exp) er++;
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (h !== 6) $display("FAIL small_hdr got %0d want 6", h);
    else passed++;
    checks++;
    if (dn !== 256 || er !== 0)
      $display("FAIL small_data got %0d errs=%0d want 256 0", dn, er);
    else passed++;
    checks++;
    if (cm !== 1) $display("FAIL small_complete got %0d want 1", cm);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mask_zero();
    test_full();
    test_mask_skip();
    test_stall();
    test_reset_mid();
    test_small();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uram_event_readout_sm_v2.md
Name: uram_event_readout_sm_v2

Overview:
Parametrised successor to the URAM event readout sequencer. It walks a cascaded URAM/BRAM event buffer: NHDR header words first, then every enabled channel's NBRAM cascaded memories, address by address. The block drives memory enables, cascade mux controls, channel selects and a valid flag toward the event-output formatter. New relative to the first generation: generic channel, cascade-depth and address widths; a per-event channel mask that skips channels; `ready_i` backpressure at address-group boundaries; synchronous reset.

Parameters:
NCHAN, 8, number of channels read per event
NBRAM, 3, cascaded memories per channel, read in order 0..NBRAM-1
NHDR, 4, header words per event (must be ≥2)
UADDR_BITS, 7, upper address bits per memory
LADDR_BITS, 2, lower address bits; one lower-address group = 2^LADDR_BITS ce-cycles

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
clk_ce_i  in  1  phase enable; state advances only when high
data_available_i  in  1  event ready in buffer
chan_mask_i  in  NCHAN  channel enables, sampled at event start
ready_i  in  1  downstream can accept the next address group
complete_o  out  1  one-clock flag: event fully read out
bram_addr_o  out  UADDR_BITS+LADDR_BITS  {uaddr, laddr}
bram_en_o  out  NBRAM  one-hot active memory
casdomux_o  out  NBRAM  equals ~bram_en_o
casdomuxen_o  out  1  cascade mux load flag
channel_en_o  out  NCHAN  one-hot active channel
sel_header_o  out  1  high while header words are output
header_rd_o  out  1  one-clock flag: pop header FIFO
valid_o  out  1  output data valid

Behaviour:
- Reset value of every output:
  - 0 for `bram_en_o`, `channel_en_o`, `bram_addr_o`, `valid_o`, `complete_o`, `header_rd_o`, `casdomuxen_o` and `sel_header_o`.
  - `casdomux_o` is all-ones.
- Reset mid-event: FSM returns to IDLE. All counters clear. `complete_o` is not generated.
- States and transitions: IDLE, HDR, DATA, STALL. All transitions and counter steps occur only when `clk_ce_i=1`.
- IDLE
  - `laddr` is held at 1.
  - On `data_available_i`: latch `chan_mask_i` into `mask_q`, go to HDR, set `valid_o=1`.
- HDR
  - `sel_header_o=1`; `hdr_cnt` counts 0..NHDR-1, one word per ce.
  - `laddr` increments modulo 2^LADDR_BITS every ce.
  - `header_rd_o` and `casdomuxen_o` pulse (gated by `clk_ce_i`) on the final header ce.
  - On that final ce: `bram_en_o` ← 1 (bit 0); `channel_en_o` ← lowest set bit of `mask_q`; go to DATA.
  - If `mask_q==0`: skip DATA, pulse `complete_o` on the final header ce, return to IDLE with `valid_o` dropping.
- DATA
  - `laddr` increments every ce.
  - At `laddr==max`: `casdomuxen_o` pulses; `bram_en_o` rotates left one position.
  - When `bram_en_o[NBRAM-1]` and `laddr==max`: `uaddr` increments.
  - Channel end is the last memory with `bram_addr_o` all-ones. On that ce:
    - `uaddr` wraps to 0.
    - `channel_en_o` moves to the next higher set bit of `mask_q`. This happens one clk before the ce edge (first non-ce clock after the condition), so the output mux settles.
  - Event end is channel end on the highest enabled channel:
    - `complete_o` pulses on that ce.
    - `valid_o` clears.
    - `bram_en_o` and `channel_en_o` clear.
    - FSM goes to IDLE.
- Backpressure: `ready_i` is sampled only on a DATA ce with `laddr==max` and not event end.
  - If low: go to STALL. `laddr`, `uaddr`, `bram_en_o` and `channel_en_o` freeze. `casdomuxen_o` is suppressed. `valid_o=0`.
  - STALL exits on the first ce with `ready_i=1`. That ce performs the deferred boundary step exactly as DATA would, and restores `valid_o=1`.
- `data_available_i` is ignored outside IDLE. Back-to-back events start on the ce after `complete_o`.
- Cycle-level data sequence: data for laddr n appears two ce-cycles after address n. Downstream handles this; the block only guarantees the address/enable ordering above.
- Widths:
  - `uaddr` wraps naturally at 2^UADDR_BITS.
  - Channel selection uses a priority search over `mask_q` above the current bit; no arithmetic overflow is possible.

Test Plan:
1. Defaults, `mask=8'hFF`, `ready_i=1`, `clk_ce_i` every other clk, one event → exactly 4 header ce-cycles + 8×3×512=12288 data ce-cycles; one `complete_o` pulse; `header_rd_o` exactly once; `bram_addr_o` covers 0..511 per memory in order.
2. `mask=8'b1000_0101` → channel_en sequence 0x01, 0x04, 0x80; 3×1536 data ce-cycles; `complete_o` after channel 7 addr 0x1FF on memory 2.
3. `mask=0` → 4 header ce-cycles, `complete_o` on the 4th, `valid_o` high exactly 4 ce-cycles; `bram_en_o` never nonzero.
4. `ready_i` low for 10 ce-cycles at uaddr 5 group end on memory 1 → outputs frozen, `valid_o=0`, no `casdomuxen_o`; on release `bram_en_o` goes to 3'b100 and addresses continue with no skipped or repeated group.
5. `rst_i` asserted mid-DATA (channel 3) → next clk all outputs at reset values; a new event after release starts cleanly with header.
6. NCHAN=4, NBRAM=2, UADDR_BITS=3, NHDR=6 → 6 header ce-cycles + 4×2×32 data ce-cycles; `complete_o` once.
